serial_alu: RTL and testbench
=============================

Name: serial_alu

Overview:
- Parametrised, bit-serial successor to the 1-bit logic/arithmetic cell.
- Reuses one 1-bit cell every cycle to process a WIDTH-bit operand pair, LSB first, under a start/done handshake.
- Used where area matters more than latency: datapath lab designs and small controllers that sequence ALU operations.

Parameters:
- WIDTH, 8, operand/result width in bits; legal values are 2 to 32.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- arit  input  1  mode select: 0 = logic, 1 = arithmetic; captured on start.
- s  input  2  operation select; captured on start.
- c_in  input  1  carry-in for add; captured on start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  registered result.
- c_out  output  1  final carry (arithmetic), 0 in logic mode.
- zero  output  1  result == 0, valid with and after done.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values (all outputs, any state, including mid-operation): state IDLE, busy=0, done=0, result=0, c_out=0, zero=0, bit counter=0, carry register=0. Any in-flight operation is discarded.
- States:
  - IDLE: start=1 → latch a, b, arit, s, c_in; go to RUN; counter=0.
  - RUN: busy=1; each edge processes bit[counter]; counter increments; after bit WIDTH-1, go to DONE.
  - DONE: done=1 for exactly one cycle. Then start=1 → new accept, go to RUN (back-to-back allowed); else go to IDLE.
- start in RUN is ignored (no queueing). Input changes during RUN have no effect.
- Latency: done is high in the cycle after the WIDTH-th edge following the accepting edge.
- Logic mode (arit=0), per bit: s=00 a&b, s=01 a|b, s=10 a^b, s=11 ~a. c_out=0.
- Arithmetic mode (arit=1):
  - s[0]=0 → add: A+B+c_in.
  - s[0]=1 → subtract: A+~B+1; c_in is ignored; c_out=1 means no borrow.
  - s[1] is reserved and must be 0; if set, behave identically to s[1]=0.
- Operand shift registers shift right one bit per RUN edge. Result bits enter at the MSB so the result is LSB-aligned after WIDTH edges. Carry register seeds from c_in (add) or 1 (subtract).
- result, c_out and zero update together on the DONE-entry edge and hold until the next DONE entry or reset. result does not change during RUN as seen at the port.
- Overflow of the unsigned sum is reflected only in c_out; result wraps modulo 2^WIDTH.

Optional Feature:
- Macro SERIAL_ALU_OVF_EN.
- Defined: adds output port ovf (1 bit), the signed two's-complement overflow (carry into MSB XOR carry out of MSB).
  - Valid in arithmetic mode, 0 in logic mode.
  - Updates with result; reset 0.
- Undefined: no ovf port and no extra logic; all other behaviour identical.

Decomposition:
- Shared package/header alu_defs: s-field constants (OP_AND, OP_OR, OP_XOR, OP_NOTA, OP_ADD, OP_SUB), state encodings (ST_IDLE, ST_RUN, ST_DONE), counter width via $clog2(WIDTH).
- Sub-module alu_bit_cell: combinational 1-bit cell.
  - Inputs: a, b, cin, arit, s.
  - Outputs: out, cout.
  - serial_alu instantiates exactly one, with subtract inversion applied outside the cell.

Test Plan:
- WIDTH=8, add 0x7F+0x01, c_in=0 → result 0x80, c_out=0, zero=0, ovf=1 if enabled; done exactly 8 edges after the accepting edge; busy high for 8 cycles.
- Add 0xFF+0x01, c_in=0 → result 0x00, c_out=1, zero=1; add 0x10+0x20, c_in=1 → result 0x31, c_out=0.
- Subtract 0x05−0x07 → result 0xFE, c_out=0; subtract 0x07−0x05 → result 0x02, c_out=1.
- Logic: 0xF0^0xFF → 0x0F; 0xF0&0x3C → 0x30; s=11, a=0xA5 → 0x5A; c_out=0 in all cases.
- Hold start high continuously: operations run back-to-back, done pulses every 9 cycles; a start pulse mid-RUN is ignored; changing a/b mid-RUN leaves the result unchanged.
- Assert rst_n=0 at bit 4 of an add → all outputs 0 immediately, no done pulse; after release, a fresh 0x01+0x01 → result 0x02.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// alu_defs: shared op-select codes, FSM states and counter sizing for serial_alu.
package alu_defs;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/serial_alu_bit_cell.sv
// alu_bit_cell: combinational 1-bit logic/full-adder cell; subtract inversion is done by the caller.
module alu_bit_cell
  import alu_defs::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       arit,
  input  logic [1:0] s,
  output logic       out,
  output logic       cout
);
  assign out  = arit ? (a ^ b ^ cin) :
                (s == OP_AND) ? (a & b) :
                (s == OP_OR)  ? (a | b) :
                (s == OP_XOR) ? (a ^ b) : ~a;
  assign cout = arit & ((a & b) | (a & cin) | (b & cin));
endmodule

// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU reusing one alu_bit_cell per cycle, LSB first, start/done handshake.
// Define SERIAL_ALU_OVF_EN to add the signed-overflow output ovf.
module serial_alu
  import alu_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             arit,
  input  logic [1:0]       s,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             zero
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = cnt_w(WIDTH);
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic             arit_q, arit_d, carry_q, carry_d;
  logic [1:0]       s_q, s_d;
  logic             busy_q, busy_d, done_q, done_d, c_out_q, c_out_d, zero_q, zero_d;
  logic             cell_b, cell_out, cell_cout;
`ifdef SERIAL_ALU_OVF_EN
  logic             ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif

  assign cell_b = b_q[0] ^ (arit_q & s_q[0]);

  alu_bit_cell u_cell (
    .a    (a_q[0]),
    .b    (cell_b),
    .cin  (carry_q),
    .arit (arit_q),
    .s    (s_q),
    .out  (cell_out),
    .cout (cell_cout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    arit_d   = arit_q;
    s_d      = s_q;
    carry_d  = carry_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    c_out_d  = c_out_q;
    zero_d   = zero_q;
`ifdef SERIAL_ALU_OVF_EN
    ovf_d    = ovf_q;
`endif
    if (state_q == ST_RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      acc_d   = {cell_out, acc_q[WIDTH-1:1]};
      carry_d = cell_cout;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d  = ST_DONE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = acc_d;
        c_out_d  = cell_cout;
        zero_d   = (acc_d == '0);
`ifdef SERIAL_ALU_OVF_EN
        // carry_q here is the carry into the MSB
        ovf_d    = arit_q & (carry_q ^ cell_cout);
`endif
      end
    end else if (start) begin
      state_d = ST_RUN;
      busy_d  = 1'b1;
      cnt_d   = '0;
      a_d     = a;
      b_d     = b;
      arit_d  = arit;
      s_d     = s;
      carry_d = arit & (s[0] | c_in);
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      arit_q   <= 1'b0;
      s_q      <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      zero_q   <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      arit_q   <= arit_d;
      s_q      <= s_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      zero_q   <= zero_d;
`ifdef SERIAL_ALU_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign c_out  = c_out_q;
  assign zero   = zero_q;
endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: randomized scoreboard bench for serial_alu (WIDTH=8); honours SERIAL_ALU_OVF_EN.
module tb_serial_alu;
  localparam int W = 8;
  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
  } exp_t;

  logic         clk, rst_n, start, arit, c_in, busy, done, c_out, zero;
  logic [W-1:0] a, b, result, prev_res;
  logic [1:0]   s;
`ifdef SERIAL_ALU_OVF_EN
  logic         ovf;
`endif
  exp_t         sb[$];
  int           checks = 0, failures = 0;

  serial_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .arit   (arit),
    .s      (s),
    .c_in   (c_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .zero   (zero)
`ifdef SERIAL_ALU_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic ar, logic [1:0] op, logic ci);
    exp_t r;
    logic [W:0] sum;
    logic [W-1:0] yy;
    r.c = 1'b0;
    r.v = 1'b0;
    if (!ar) begin
      r.res = (op == 2'd0) ? (x & y) : (op == 2'd1) ? (x | y) : (op == 2'd2) ? (x ^ y) : ~x;
    end else begin
      yy    = op[0] ? ~y : y;
      sum   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (op[0] ? 1'b1 : ci)};
      r.res = sum[W-1:0];
      r.c   = sum[W];
      r.v   = (x[W-1] == yy[W-1]) && (r.res[W-1] != x[W-1]);
    end
    r.z = (r.res == '0);
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Scoreboard monitor: compares every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && busy) check("hold_during_run", result, prev_res);
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("c_out", c_out, e.c);
        check("zero", zero, e.z);
`ifdef SERIAL_ALU_OVF_EN
        check("ovf", ovf, e.v);
`endif
      end
    end
    prev_res = result;
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ar, input logic [1:0] op, input logic ci);
    a = x; b = y; arit = ar; s = op; c_in = ci; start = 1'b1;
    sb.push_back(model(x, y, ar, op, ci));
  endtask

  task automatic issue_rand();
    issue(W'($urandom), W'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
  endtask

  // Called just after an accepting edge; counts edges until done is seen.
  task automatic wait_done(output int e, output int bc);
    e = 0;
    bc = 0;
    do begin
      @(posedge clk);
      #1;
      e++;
      if (busy) bc++;
    end while (!done && e < 20);
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ar, input logic [1:0] op, input logic ci);
    int e, bc;
    @(negedge clk);
    issue(x, y, ar, op, ci);
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_accept", busy, 1);
    wait_done(e, bc);
    check("latency", e, 8);
    check("busy_cycles", bc + 1, 8);
    @(posedge clk);
    #1 check("done_one_cycle", done, 0);
  endtask

  task automatic b2b(input int n);
    int e, bc;
    time t_prev, t_now;
    t_prev = 0;
    @(negedge clk);
    issue_rand();
    @(posedge clk);
    for (int i = 0; i < n; i++) begin
      #1;
      if (i < n - 1) issue_rand();
      else start = 1'b0;
      wait_done(e, bc);
      check("b2b_latency", e, 8);
      t_now = $time;
      if (i > 0) check("b2b_period", 32'(t_now - t_prev), 90);
      t_prev = t_now;
      @(posedge clk);
    end
  endtask

  initial begin
    int e, bc;
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; arit = 1'b0; s = '0; c_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_c_out", c_out, 0);
    check("rst_zero", zero, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h7F, 8'h01, 1'b1, 2'b00, 1'b0);
    run_op(8'hFF, 8'h01, 1'b1, 2'b00, 1'b0);
    run_op(8'h10, 8'h20, 1'b1, 2'b00, 1'b1);
    run_op(8'h05, 8'h07, 1'b1, 2'b01, 1'b1);
    run_op(8'h07, 8'h05, 1'b1, 2'b01, 1'b0);
    run_op(8'h07, 8'h05, 1'b1, 2'b11, 1'b0);
    run_op(8'hF0, 8'hFF, 1'b0, 2'b10, 1'b1);
    run_op(8'hF0, 8'h3C, 1'b0, 2'b00, 1'b1);
    run_op(8'hA5, 8'h00, 1'b0, 2'b11, 1'b1);
    run_op(8'hF0, 8'h0F, 1'b0, 2'b01, 1'b0);
    for (int i = 0; i < 30; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
    b2b(6);
    // start pulse and operand changes mid-run must not disturb the active operation
    @(negedge clk);
    issue(8'h33, 8'h44, 1'b1, 2'b00, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 begin start = 1'b1; a = 8'hFF; b = 8'hFF; arit = 1'b0; s = 2'b11; end
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(e, bc);
    check("midrun_latency", e, 4);
    repeat (12) @(posedge clk);
    check("midrun_no_extra", sb.size(), 0);
    // asynchronous reset while bit 4 of an add is in flight
    run_op(8'h12, 8'h34, 1'b1, 2'b00, 1'b0);
    @(negedge clk);
    issue(8'h55, 8'h22, 1'b1, 2'b00, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_result", result, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_c_out", c_out, 0);
    check("arst_zero", zero, 0);
`ifdef SERIAL_ALU_OVF_EN
    check("arst_ovf", ovf, 0);
`endif
    sb.delete();
    repeat (2) @(negedge clk);
    check("arst_no_done", done, 0);
    rst_n = 1'b1;
    run_op(8'h01, 8'h01, 1'b1, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
